// File: rtl/line_sched_pkg.sv
// Shared types and helpers for the line-draw scheduler: FSM states, coordinate width,
// and the unsigned absolute difference used for line-length computation.
package line_sched_pkg;

  localparam int unsigned CW   = 11;
  localparam int unsigned NREQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a >= b) ? CW'(a - b) : CW'(b - a);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/line_draw_scheduler.sv
// Front end for the Bresenham line drawer: arbitrates two command ports, resets the
// drawer per line, streams exactly len+1 pixels and pulses done to the owner.
module line_draw_scheduler #(
  parameter int unsigned CW   = line_sched_pkg::CW,
  parameter int unsigned NREQ = line_sched_pkg::NREQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*CW-1:0] req_x0,
  input  logic [NREQ*CW-1:0] req_y0,
  input  logic [NREQ*CW-1:0] req_x1,
  input  logic [NREQ*CW-1:0] req_y1,
  input  logic [NREQ-1:0]    req_color,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic               ld_reset,
  output logic [CW-1:0]      ld_x0,
  output logic [CW-1:0]      ld_y0,
  output logic [CW-1:0]      ld_x1,
  output logic [CW-1:0]      ld_y1,
  input  logic [CW-1:0]      ld_x,
  input  logic [CW-1:0]      ld_y,
  output logic               pix_valid,
  output logic [CW-1:0]      pix_x,
  output logic [CW-1:0]      pix_y,
  output logic               pix_color
);

  import line_sched_pkg::*;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          color_q, color_d;
  logic [CW-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [CW-1:0] len_q, len_d, cnt_q, cnt_d;

  logic [1:0]    grant_c;
  logic          gidx_c, accept_c, sel_color_c;
  logic [CW-1:0] sel_x0_c, sel_y0_c, sel_x1_c, sel_y1_c, dx_c, dy_c;

  rr_arbiter2 u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_c)
  );

  // Ready is offered only in IDLE and never while reset is held.
  assign req_ready   = (state_q == IDLE && reset) ? grant_c : '0;
  assign accept_c    = |(req_valid & req_ready);
  assign gidx_c      = grant_c[1];
  assign sel_x0_c    = gidx_c ? req_x0[CW +: CW] : req_x0[0 +: CW];
  assign sel_y0_c    = gidx_c ? req_y0[CW +: CW] : req_y0[0 +: CW];
  assign sel_x1_c    = gidx_c ? req_x1[CW +: CW] : req_x1[0 +: CW];
  assign sel_y1_c    = gidx_c ? req_y1[CW +: CW] : req_y1[0 +: CW];
  assign sel_color_c = gidx_c ? req_color[1] : req_color[0];
  assign dx_c        = abs_diff(sel_x0_c, sel_x1_c);
  assign dy_c        = abs_diff(sel_y0_c, sel_y1_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      color_q      <= 1'b0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      color_q      <= color_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    color_d      = color_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    busy         = (state_q != IDLE);
    ld_reset     = 1'b0;
    pix_valid    = 1'b0;
    done         = '0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          gnt_d        = gidx_c;
          last_grant_d = gidx_c;
          color_d      = sel_color_c;
          x0_d         = sel_x0_c;
          y0_d         = sel_y0_c;
          x1_d         = sel_x1_c;
          y1_d         = sel_y1_c;
          len_d        = (dx_c > dy_c) ? dx_c : dy_c;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        ld_reset = 1'b1;
        cnt_d    = '0;
        state_d  = DRAW;
      end
      DRAW: begin
        // The count stops at len, so it cannot wrap even for a 2047-pixel span.
        pix_valid = 1'b1;
        if (cnt_q == len_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done    = NREQ'(1) << gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_x0     = x0_q;
  assign ld_y0     = y0_q;
  assign ld_x1     = x1_q;
  assign ld_y1     = y1_q;
  assign pix_x     = ld_x;
  assign pix_y     = ld_y;
  assign pix_color = color_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Bench for line_draw_scheduler: behavioural Bresenham drawer plus directed and
// randomized command streams checked against an arbitration/line-length model.
module tb_line_draw_scheduler;

  localparam int unsigned CW = 11;

  logic            clk;
  logic            reset;
  logic [1:0]      req_valid, req_ready, req_color, done;
  logic [2*CW-1:0] req_x0, req_y0, req_x1, req_y1;
  logic            busy, ld_reset, pix_valid, pix_color;
  logic [CW-1:0]   ld_x0, ld_y0, ld_x1, ld_y1, ld_x, ld_y, pix_x, pix_y;

  int checks = 0;
  int errors = 0;

  int         cx0 [2], cy0 [2], cx1 [2], cy1 [2];
  bit         ccol [2];
  logic [1:0] vld;
  int         model_last;

  logic [2*CW-1:0] fixed_pts [8];
  int              fixed_n;

  line_draw_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_y0    (req_y0),
    .req_x1    (req_x1),
    .req_y1    (req_y1),
    .req_color (req_color),
    .done      (done),
    .busy      (busy),
    .ld_reset  (ld_reset),
    .ld_x0     (ld_x0),
    .ld_y0     (ld_y0),
    .ld_x1     (ld_x1),
    .ld_y1     (ld_y1),
    .ld_x      (ld_x),
    .ld_y      (ld_y),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_valid = vld;
    req_x0    = {CW'(cx0[1]), CW'(cx0[0])};
    req_y0    = {CW'(cy0[1]), CW'(cy0[0])};
    req_x1    = {CW'(cx1[1]), CW'(cx1[0])};
    req_y1    = {CW'(cy1[1]), CW'(cy1[0])};
    req_color = {ccol[1], ccol[0]};
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // k-th pixel of a Bresenham walk (major axis ascending); returns {x, y}.
  function automatic logic [2*CW-1:0] bres_point(input int ax0, input int ay0,
                                                 input int ax1, input int ay1, input int k);
    int x0, y0, x1, y1, t, dx, dy, err, ystep, y;
    bit steep;
    logic [2*CW-1:0] r;
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx = x1 - x0;
    dy = iabs(y1 - y0);
    err = -(dx / 2);
    ystep = (y0 < y1) ? 1 : -1;
    y = y0;
    r = '0;
    for (int x = x0; x <= x1; x++) begin
      r = steep ? {CW'(y), CW'(x)} : {CW'(x), CW'(y)};
      if (x - x0 == k) break;
      err += dy;
      if (dy != 0 && err >= 0) begin
        y += ystep;
        err -= dx;
      end
    end
    return r;
  endfunction

  // Behavioural line drawer: restarts on ld_reset, then emits one pixel per cycle.
  int dr_x0, dr_y0, dr_x1, dr_y1, dr_idx;
  logic [2*CW-1:0] dr_pt;

  always_ff @(posedge clk) begin
    if (ld_reset === 1'b1) begin
      dr_idx <= 0;
      dr_x0  <= int'(ld_x0);
      dr_y0  <= int'(ld_y0);
      dr_x1  <= int'(ld_x1);
      dr_y1  <= int'(ld_y1);
    end else if (dr_idx < 4095) begin
      dr_idx <= dr_idx + 1;
    end
  end

  always_comb begin
    dr_pt = bres_point(dr_x0, dr_y0, dr_x1, dr_y1, dr_idx);
    ld_x  = dr_pt[2*CW-1:CW];
    ld_y  = dr_pt[CW-1:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cmd(input int r, input int x0, input int y0, input int x1, input int y1,
                          input bit col);
    cx0[r] = x0; cy0[r] = y0; cx1[r] = x1; cy1[r] = y1; ccol[r] = col;
  endtask

  task automatic post(input int r, input int x0, input int y0, input int x1, input int y1,
                      input bit col);
    load_cmd(r, x0, y0, x1, y1, col);
    vld[r] = 1'b1;
  endtask

  task automatic fx(input int k, input int x, input int y);
    fixed_pts[k] = {CW'(x), CW'(y)};
    fixed_n = k + 1;
  endtask

  // Serve one command from IDLE through the IDLE cycle after its done pulse.
  task automatic serve(input int raise_r);
    int w, n, dx, dy;
    logic [2*CW-1:0] pt;
    w = (vld == 2'b11) ? 1 - model_last : (vld[1] ? 1 : 0);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("grant", 32'(req_ready), 32'd1 << w);
    step();
    vld[w] = 1'b0;
    model_last = w;
    chk("load_ld_reset", 32'(ld_reset), 32'd1);
    chk("load_pix_valid", 32'(pix_valid), 32'd0);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(req_ready), 32'd0);
    chk("ld_x0", 32'(ld_x0), cx0[w]);
    chk("ld_y0", 32'(ld_y0), cy0[w]);
    chk("ld_x1", 32'(ld_x1), cx1[w]);
    chk("ld_y1", 32'(ld_y1), cy1[w]);
    dx = iabs(cx1[w] - cx0[w]);
    dy = iabs(cy1[w] - cy0[w]);
    n = ((dx > dy) ? dx : dy) + 1;
    if (fixed_n > 0) chk("fixed_len", n, fixed_n);
    step();
    for (int k = 0; k < n; k++) begin
      if (k == 1 && raise_r >= 0) begin
        vld[raise_r] = 1'b1;
        #1;
      end
      pt = bres_point(cx0[w], cy0[w], cx1[w], cy1[w], k);
      chk("pix_valid", 32'(pix_valid), 32'd1);
      chk("pix_xy", 32'({pix_x, pix_y}), 32'(pt));
      if (fixed_n > k) chk("pix_fixed", 32'({pix_x, pix_y}), 32'(fixed_pts[k]));
      chk("pix_color", 32'(pix_color), 32'(ccol[w]));
      chk("draw_done", 32'(done), 32'd0);
      chk("draw_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("done_pulse", 32'(done), 32'd1 << w);
    chk("done_pix_valid", 32'(pix_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd1);
    step();
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_done", 32'(done), 32'd0);
    fixed_n = 0;
  endtask

  initial begin
    int pat;
    vld = 2'b00;
    fixed_n = 0;
    model_last = 1;
    for (int r = 0; r < 2; r++) load_cmd(r, 0, 0, 0, 0, 1'b0);

    // Reset state, with a request pending that must not see ready.
    reset = 1'b0;
    post(0, 1, 2, 3, 4, 1'b1);
    #3;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_reset", 32'(ld_reset), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ld_x1", 32'(ld_x1), 32'd0);
    chk("rst_color", 32'(pix_color), 32'd0);
    step();
    step();
    vld = 2'b00;
    reset = 1'b1;
    step();

    // Horizontal line, requester 0.
    post(0, 0, 0, 3, 0, 1'b1);
    fx(0, 0, 0); fx(1, 1, 0); fx(2, 2, 0); fx(3, 3, 0);
    serve(-1);

    // Steep line, requester 1.
    post(1, 0, 0, 2, 5, 1'b0);
    fx(0, 0, 0); fx(1, 1, 1); fx(2, 1, 2); fx(3, 1, 3); fx(4, 2, 4); fx(5, 2, 5);
    serve(-1);

    // Contention after a requester-1 line: requester 0 goes first, twice.
    post(0, 0, 0, 1, 0, 1'b1);
    post(1, 5, 5, 5, 6, 1'b0);
    #1;
    chk("cont1_first", 32'(req_ready), 32'd1);
    fx(0, 0, 0); fx(1, 1, 0);
    serve(-1);
    fx(0, 5, 5); fx(1, 5, 6);
    serve(-1);
    post(0, 2, 2, 4, 3, 1'b0);
    post(1, 9, 1, 6, 1, 1'b1);
    #1;
    chk("cont2_first", 32'(req_ready), 32'd1);
    serve(-1);
    serve(-1);

    // Point line.
    post(0, 7, 7, 7, 7, 1'b1);
    fx(0, 7, 7);
    serve(-1);

    // Hold-off: requester 1 raises valid mid-draw and starts right after done.
    load_cmd(1, 4, 0, 0, 3, 1'b1);
    post(0, 0, 0, 6, 2, 1'b0);
    serve(1);
    serve(-1);

    // Asynchronous reset in the middle of a line.
    post(0, 0, 0, 10, 0, 1'b1);
    #1;
    chk("mid_grant", 32'(req_ready), 32'd1);
    step();
    vld[0] = 1'b0;
    step();
    for (int k = 0; k < 4; k++) step();
    chk("mid_pix_valid_pre", 32'(pix_valid), 32'd1);
    chk("mid_pix_x_pre", 32'(pix_x), 32'd4);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_pix_valid", 32'(pix_valid), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_ld_x1", 32'(ld_x1), 32'd0);
    step();
    step();
    chk("mid_done_held", 32'(done), 32'd0);
    reset = 1'b1;
    model_last = 1;
    step();
    post(0, 3, 3, 6, 6, 1'b0);
    fx(0, 3, 3); fx(1, 4, 4); fx(2, 5, 5); fx(3, 6, 6);
    serve(-1);

    // Randomized command mix.
    for (int i = 0; i < 24; i++) begin
      pat = int'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (pat[r]) post(r, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                         int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                         1'($urandom_range(0, 1)));
      end
      serve(-1);
      if (vld != 2'b00) serve(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_draw_scheduler.md
Name: line_draw_scheduler

Overview:
- Two-requester front end for the Bresenham line_drawer datapath.
- Accepts line commands on two valid/ready ports and arbitrates between them round-robin. For each granted command it latches the endpoints and colour, pulses the drawer reset, and streams the resulting pixels with a valid strobe.
- Counts the pixels of each line so completion is exact, then pulses a per-requester done.
- Sits between the drawing sources (e.g. draw and erase engines) and the framebuffer write port.

Parameters:
- CW, 11, coordinate width (matches line_drawer).
- NREQ, 2, number of requesters. Fixed at 2; the parameter exists for port sizing only.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  2  command valid, one bit per requester.
- req_ready  out  2  command accept, one bit per requester.
- req_x0, req_y0, req_x1, req_y1  in  2*CW each  endpoints; requester i occupies bits [i*CW +: CW].
- req_color  in  2  pixel colour, one bit per requester.
- done  out  2  one-cycle pulse when requester i's line has finished.
- busy  out  1  high in every state except IDLE.
- ld_reset  out  1  drives line_drawer reset.
- ld_x0, ld_y0, ld_x1, ld_y1  out  CW each  latched endpoints to line_drawer.
- ld_x, ld_y  in  CW each  pixel coordinates from line_drawer.
- pix_valid  out  1  pixel write strobe.
- pix_x, pix_y  out  CW each  pixel coordinates.
- pix_color  out  1  pixel colour.

Behaviour:
- States: IDLE, LOAD, DRAW, DONE.
- Reset values (async, while reset==0):
  - State IDLE; all latched endpoints 0; colour 0; count 0.
  - last_grant = 1, so requester 0 wins first.
  - ld_reset=0, pix_valid=0, done=0, busy=0, req_ready=0.
- Arbitration in IDLE, combinational:
  - If exactly one req_valid is set, grant that requester.
  - If both are set, grant ~last_grant.
  - req_ready[g]=1 only for the granted requester, and only in IDLE. req_ready never depends on the other requester's ready.
- Accept:
  - Handshake occurs when req_valid[g] && req_ready[g].
  - On the handshake, latch endpoints, colour and the grant index; set last_grant=g; go to LOAD.
  - At the same edge, load len = max(|x1-x0|, |y1-y0|), computed as CW-bit unsigned absolute differences.
- LOAD (1 cycle):
  - ld_reset=1. ld_* endpoints hold the latched values and stay stable until the next accept.
  - Next state is DRAW; count=0.
- DRAW:
  - pix_valid=1, pix_x=ld_x, pix_y=ld_y, pix_color=latched colour. Outputs are combinational pass-through with no added latency.
  - count increments every cycle.
  - When count==len, the current cycle is the last pixel; next state is DONE.
  - A line emits exactly len+1 pixels. A point line (x0==x1, y0==y1) emits 1 pixel.
  - Pixel order follows line_drawer, which may run from either endpoint.
- DONE (1 cycle): done[latched grant]=1, pix_valid=0; next state IDLE.
- Back-to-back commands:
  - A new command may be accepted in the IDLE cycle immediately after DONE.
  - Minimum per-line overhead is 3 cycles (IDLE, LOAD, DONE).
- No pixel back-pressure: the framebuffer must accept one write per cycle.
- Commands presented while busy are held off (req_ready=0). The requester must keep valid and data stable until the handshake.
- Async reset mid-line: everything returns to reset values immediately. No done is issued for the aborted line. The drawer state is left as is; it is reinitialised by the next LOAD.
- Width rules:
  - len is CW bits (max 2047).
  - count is CW bits and never wraps, because it stops at len.

Decomposition:
- Package line_sched_pkg holds:
  - the state enum (IDLE, LOAD, DRAW, DONE);
  - the CW localparam;
  - an abs_diff function shared with length computation.
- Sub-module rr_arbiter2: 2-way round-robin arbiter.
  - Inputs: req[1:0] and last_grant.
  - Outputs: one-hot grant.
  - Purely combinational.
- The line_drawer itself is instantiated at the level above, not inside this block.

Test Plan:
- Single horizontal line: req0 (0,0)->(3,0) colour 1.
  - Required: ready0 high for the accept cycle, LOAD 1 cycle with ld_reset=1.
  - Then pix_valid for 4 cycles with pix=(0,0),(1,0),(2,0),(3,0), colour 1.
  - Then done[0] pulses once; busy falls the next cycle.
- Steep line: req1 (0,0)->(2,5).
  - Required: 6 pixels (0,0),(1,1),(1,2),(1,3),(2,4),(2,5), then done[1].
- Point line: req0 (7,7)->(7,7) -> exactly one pixel (7,7), then done[0].
- Contention: both valid at once with lines (0,0)->(1,0) and (5,5)->(5,6).
  - Required: req0 is served first, req1 next.
  - Then both valid again with new commands: req0 is served first again, because last_grant=1.
  - No interleaving of pixels between lines.
- Hold-off: raise req1 valid during req0's DRAW.
  - Required: ready1 stays 0 until IDLE, then accepts; the second line starts exactly 1 cycle after done[0].
- Mid-line reset: drop reset during DRAW of (0,0)->(10,0) at pixel 4.
  - Required: busy, pix_valid and done all 0 immediately.
  - After release, a new req0 (3,3)->(6,6) draws 4 correct pixels.
